// File: rtl/mem_bus_arbiter_if.sv
// Core-side fetch/data ports and memory-side req/ack bus shared by the arbiter.
// slave = arbiter view, master = core + memory environment view.
interface mem_bus_arbiter_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        iready_n;
  logic        ierr;
  logic        dreq;
  logic        dwrite;
  logic [1:0]  dsize;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dready_n;
  logic        dbusy;
  logic        derr;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  modport slave (
    input  ireq, iaddr, dreq, dwrite, dsize, daddr, dwdata, m_rdata, m_ack,
    output idata, iready_n, ierr, drdata, dready_n, dbusy, derr,
           m_req, m_write, m_size, m_addr, m_wdata
  );

  modport master (
    output ireq, iaddr, dreq, dwrite, dsize, daddr, dwdata, m_rdata, m_ack,
    input  idata, iready_n, ierr, drdata, dready_n, dbusy, derr,
           m_req, m_write, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory req/ack bus between instruction fetch and data access,
// with a data-starvation guard, alignment checking and an access timeout.
//
// state | meaning
// IDLE  | sample ireq/dreq and grant one side (or fail it on misalignment)
// IGNT  | fetch in flight on the memory bus
// DGNT  | data access in flight on the memory bus
// RESP  | one-cycle active-low ready strobe to the granted side
module mem_bus_arbiter #(
  parameter int unsigned DSTARVE = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT, RESP} state_e;

  localparam logic [3:0]  DSTARVE_C = 4'(DSTARVE);
  localparam logic [15:0] TLIMIT    = 16'(TIMEOUT - 1);
  localparam bit          TO_EN     = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        dside_q, dside_d;
  logic [31:0] idata_q, idata_d, drdata_q, drdata_d;
  logic        iready_n_q, iready_n_d, dready_n_q, dready_n_d;
  logic        ierr_q, ierr_d, derr_q, derr_d, dbusy_q, dbusy_d;
  logic        m_req_q, m_req_d, m_write_q, m_write_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;

  function automatic logic d_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   d_misaligned = 1'b0;
      2'b01:   d_misaligned = a[0];
      2'b10:   d_misaligned = (a != 2'b00);
      default: d_misaligned = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      tcnt_q     <= '0;
      dside_q    <= 1'b0;
      idata_q    <= '0;
      drdata_q   <= '0;
      iready_n_q <= 1'b1;
      dready_n_q <= 1'b1;
      ierr_q     <= 1'b0;
      derr_q     <= 1'b0;
      dbusy_q    <= 1'b0;
      m_req_q    <= 1'b0;
      m_write_q  <= 1'b0;
      m_size_q   <= 2'b00;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      tcnt_q     <= tcnt_d;
      dside_q    <= dside_d;
      idata_q    <= idata_d;
      drdata_q   <= drdata_d;
      iready_n_q <= iready_n_d;
      dready_n_q <= dready_n_d;
      ierr_q     <= ierr_d;
      derr_q     <= derr_d;
      dbusy_q    <= dbusy_d;
      m_req_q    <= m_req_d;
      m_write_q  <= m_write_d;
      m_size_q   <= m_size_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  // Outputs are computed for the next state so every port comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    tcnt_d     = tcnt_q;
    dside_d    = dside_q;
    idata_d    = idata_q;
    drdata_d   = drdata_q;
    iready_n_d = 1'b1;
    dready_n_d = 1'b1;
    ierr_d     = 1'b0;
    derr_d     = 1'b0;
    dbusy_d    = 1'b0;
    m_req_d    = 1'b0;
    m_write_d  = m_write_q;
    m_size_d   = m_size_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (bus.dreq && !(bus.ireq && (dcnt_q == DSTARVE_C))) begin
          dside_d = 1'b1;
          if (!bus.ireq)               dcnt_d = '0;
          else if (dcnt_q < DSTARVE_C) dcnt_d = dcnt_q + 4'd1;
          if (d_misaligned(bus.dsize, bus.daddr[1:0])) begin
            state_d    = RESP;
            dready_n_d = 1'b0;
            derr_d     = 1'b1;
            drdata_d   = '0;
          end else begin
            state_d   = DGNT;
            m_req_d   = 1'b1;
            dbusy_d   = 1'b1;
            m_write_d = bus.dwrite;
            m_size_d  = bus.dsize;
            m_addr_d  = bus.daddr;
            m_wdata_d = bus.dwdata;
          end
        end else if (bus.ireq) begin
          dside_d = 1'b0;
          dcnt_d  = '0;
          if (bus.iaddr[1:0] != 2'b00) begin
            state_d    = RESP;
            iready_n_d = 1'b0;
            ierr_d     = 1'b1;
            idata_d    = '0;
          end else begin
            state_d   = IGNT;
            m_req_d   = 1'b1;
            m_write_d = 1'b0;
            m_size_d  = 2'b10;
            m_addr_d  = bus.iaddr;
          end
        end
      end
      IGNT, DGNT: begin
        if (bus.m_ack || (TO_EN && (tcnt_q == TLIMIT))) begin
          state_d = RESP;
          if (dside_q) begin
            dready_n_d = 1'b0;
            derr_d     = !bus.m_ack;
            drdata_d   = (bus.m_ack && !m_write_q) ? bus.m_rdata : '0;
          end else begin
            iready_n_d = 1'b0;
            ierr_d     = !bus.m_ack;
            idata_d    = bus.m_ack ? bus.m_rdata : '0;
          end
        end else begin
          tcnt_d  = tcnt_q + 16'd1;
          m_req_d = 1'b1;
          dbusy_d = (state_q == DGNT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.idata    = idata_q;
  assign bus.iready_n = iready_n_q;
  assign bus.ierr     = ierr_q;
  assign bus.drdata   = drdata_q;
  assign bus.dready_n = dready_n_q;
  assign bus.dbusy    = dbusy_q;
  assign bus.derr     = derr_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_write  = m_write_q;
  assign bus.m_size   = m_size_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, alignment errors,
// timeout, reset abort and back-to-back fetch streaming.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.DSTARVE(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Zero-wait memory returns a value derived from the address; manual mode is scripted.
  assign bus.m_ack   = auto_ack ? bus.m_req : man_ack;
  assign bus.m_rdata = auto_ack ? (bus.m_addr ^ 32'h5A5A_0000) : man_rdata;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ireq = 1'b0; bus.iaddr = '0;
    bus.dreq = 1'b0; bus.dwrite = 1'b0; bus.dsize = 2'b00;
    bus.daddr = '0; bus.dwdata = '0;
    man_ack = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 12;
    if (bus.m_req !== 1'b0)    begin failures++; $display("FAIL rst_m_req got=%b exp=0", bus.m_req); end
    if (bus.m_write !== 1'b0)  begin failures++; $display("FAIL rst_m_write got=%b exp=0", bus.m_write); end
    if (bus.dbusy !== 1'b0)    begin failures++; $display("FAIL rst_dbusy got=%b exp=0", bus.dbusy); end
    if (bus.ierr !== 1'b0)     begin failures++; $display("FAIL rst_ierr got=%b exp=0", bus.ierr); end
    if (bus.derr !== 1'b0)     begin failures++; $display("FAIL rst_derr got=%b exp=0", bus.derr); end
    if (bus.iready_n !== 1'b1) begin failures++; $display("FAIL rst_iready_n got=%b exp=1", bus.iready_n); end
    if (bus.dready_n !== 1'b1) begin failures++; $display("FAIL rst_dready_n got=%b exp=1", bus.dready_n); end
    if (bus.m_size !== 2'b00)  begin failures++; $display("FAIL rst_m_size got=%b exp=00", bus.m_size); end
    if (bus.m_addr !== 32'h0)  begin failures++; $display("FAIL rst_m_addr got=%h exp=0", bus.m_addr); end
    if (bus.m_wdata !== 32'h0) begin failures++; $display("FAIL rst_m_wdata got=%h exp=0", bus.m_wdata); end
    if (bus.idata !== 32'h0)   begin failures++; $display("FAIL rst_idata got=%h exp=0", bus.idata); end
    if (bus.drdata !== 32'h0)  begin failures++; $display("FAIL rst_drdata got=%h exp=0", bus.drdata); end
  endtask

  task automatic test_single_load();
    apply_reset();
    auto_ack = 1'b0;
    man_rdata = 32'hDEAD_BEEF;
    bus.dreq = 1'b1; bus.dwrite = 1'b0; bus.dsize = 2'b10; bus.daddr = 32'h100;
    checks++;
    if (bus.m_req !== 1'b0) begin failures++; $display("FAIL load_req_t got=%b exp=0", bus.m_req); end
    tick();
    checks += 3;
    if (bus.m_req !== 1'b1)   begin failures++; $display("FAIL load_req_t1 got=%b exp=1", bus.m_req); end
    if (bus.dbusy !== 1'b1)   begin failures++; $display("FAIL load_busy_t1 got=%b exp=1", bus.dbusy); end
    if (bus.m_addr !== 32'h100) begin failures++; $display("FAIL load_addr got=%h exp=100", bus.m_addr); end
    tick();
    man_ack = 1'b1;
    checks += 2;
    if (bus.dbusy !== 1'b1)    begin failures++; $display("FAIL load_busy_t2 got=%b exp=1", bus.dbusy); end
    if (bus.dready_n !== 1'b1) begin failures++; $display("FAIL load_rdy_t2 got=%b exp=1", bus.dready_n); end
    tick();
    man_ack = 1'b0;
    bus.dreq = 1'b0;
    checks += 4;
    if (bus.dready_n !== 1'b0)        begin failures++; $display("FAIL load_rdy_t3 got=%b exp=0", bus.dready_n); end
    if (bus.drdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", bus.drdata); end
    if (bus.dbusy !== 1'b0)           begin failures++; $display("FAIL load_busy_t3 got=%b exp=0", bus.dbusy); end
    if (bus.derr !== 1'b0)            begin failures++; $display("FAIL load_err got=%b exp=0", bus.derr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.dready_n !== 1'b1 || bus.m_req !== 1'b0) begin
        failures++; $display("FAIL load_quiet cyc=%0d rdy_n=%b m_req=%b exp 1/0", i, bus.dready_n, bus.m_req);
      end
    end
  endtask

  task automatic test_store();
    apply_reset();
    auto_ack = 1'b1;
    bus.dreq = 1'b1; bus.dwrite = 1'b1; bus.dsize = 2'b01;
    bus.daddr = 32'h10; bus.dwdata = 32'h0000_1234;
    tick();
    checks += 4;
    if (bus.m_write !== 1'b1)        begin failures++; $display("FAIL st_write got=%b exp=1", bus.m_write); end
    if (bus.m_size !== 2'b01)        begin failures++; $display("FAIL st_size got=%b exp=01", bus.m_size); end
    if (bus.m_addr !== 32'h10)       begin failures++; $display("FAIL st_addr got=%h exp=10", bus.m_addr); end
    if (bus.m_wdata !== 32'h1234)    begin failures++; $display("FAIL st_wdata got=%h exp=1234", bus.m_wdata); end
    tick();
    bus.dreq = 1'b0;
    checks += 2;
    if (bus.dready_n !== 1'b0) begin failures++; $display("FAIL st_rdy got=%b exp=0", bus.dready_n); end
    if (bus.drdata !== 32'h0)  begin failures++; $display("FAIL st_drdata got=%h exp=0", bus.drdata); end
    tick();
    auto_ack = 1'b0;
  endtask

  task automatic test_starvation();
    logic [9:0] exp_d;
    int         n;
    exp_d = 10'b1111011110;
    n = 0;
    apply_reset();
    auto_ack = 1'b1;
    bus.dreq = 1'b1; bus.dsize = 2'b10; bus.daddr = 32'h200;
    bus.ireq = 1'b1; bus.iaddr = 32'h300;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      if (bus.m_req === 1'b1) begin
        checks += 2;
        if (bus.dbusy !== exp_d[9 - n]) begin
          failures++; $display("FAIL starve_order grant=%0d got_d=%b exp_d=%b", n, bus.dbusy, exp_d[9 - n]);
        end
        if (bus.m_addr !== (exp_d[9 - n] ? 32'h200 : 32'h300)) begin
          failures++; $display("FAIL starve_addr grant=%0d got=%h", n, bus.m_addr);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin failures++; $display("FAIL starve_count got=%0d exp=10", n); end
    tick();
    idle_inputs();
    tick();
    tick();
    auto_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz  [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [31:0] ad  [4] = '{32'h102, 32'h101, 32'h100, 32'h103};
    logic        bad [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    auto_ack = 1'b1;
    for (int v = 0; v < 4; v++) begin
      bus.dreq = 1'b1; bus.dwrite = 1'b1; bus.dsize = sz[v]; bus.daddr = ad[v];
      tick();
      if (bad[v]) begin
        checks += 3;
        if (bus.dready_n !== 1'b0) begin failures++; $display("FAIL mis_rdy v=%0d got=%b exp=0", v, bus.dready_n); end
        if (bus.derr !== 1'b1)     begin failures++; $display("FAIL mis_err v=%0d got=%b exp=1", v, bus.derr); end
        if (bus.m_req !== 1'b0)    begin failures++; $display("FAIL mis_req v=%0d got=%b exp=0", v, bus.m_req); end
      end else begin
        checks++;
        if (bus.m_req !== 1'b1) begin failures++; $display("FAIL ok_req v=%0d got=%b exp=1", v, bus.m_req); end
        tick();
        checks += 2;
        if (bus.dready_n !== 1'b0) begin failures++; $display("FAIL ok_rdy v=%0d got=%b exp=0", v, bus.dready_n); end
        if (bus.derr !== 1'b0)     begin failures++; $display("FAIL ok_err v=%0d got=%b exp=0", v, bus.derr); end
      end
      bus.dreq = 1'b0;
      tick();
      checks++;
      if (bus.m_req !== 1'b0 || bus.dready_n !== 1'b1) begin
        failures++; $display("FAIL mis_quiet v=%0d m_req=%b rdy_n=%b exp 0/1", v, bus.m_req, bus.dready_n);
      end
      tick();
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int  hi;
    bit  seen;
    hi = 0;
    seen = 1'b0;
    apply_reset();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    man_rdata = 32'hFFFF_FFFF;
    bus.ireq = 1'b1; bus.iaddr = 32'h40;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.iready_n === 1'b0) begin
        seen = 1'b1;
        bus.ireq = 1'b0;
        checks += 2;
        if (bus.ierr !== 1'b1)    begin failures++; $display("FAIL to_ierr got=%b exp=1", bus.ierr); end
        if (bus.idata !== 32'h0)  begin failures++; $display("FAIL to_idata got=%h exp=0", bus.idata); end
      end else if (bus.m_req === 1'b1) begin
        hi++;
      end
    end
    checks += 2;
    if (!seen)   begin failures++; $display("FAIL to_strobe got=none exp=iready_n low"); end
    if (hi != 8) begin failures++; $display("FAIL to_req_cycles got=%0d exp=8", hi); end
    tick();
    tick();
  endtask

  task automatic test_reset_in_dgnt();
    apply_reset();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    bus.dreq = 1'b1; bus.dwrite = 1'b1; bus.dsize = 2'b10;
    bus.daddr = 32'h180; bus.dwdata = 32'hCAFE_0001;
    tick();
    tick();
    checks++;
    if (bus.m_addr !== 32'h180) begin failures++; $display("FAIL rdg_pre_addr got=%h exp=180", bus.m_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dreq = 1'b0;
    checks += 6;
    if (bus.m_req !== 1'b0)    begin failures++; $display("FAIL rdg_m_req got=%b exp=0", bus.m_req); end
    if (bus.dbusy !== 1'b0)    begin failures++; $display("FAIL rdg_dbusy got=%b exp=0", bus.dbusy); end
    if (bus.m_addr !== 32'h0)  begin failures++; $display("FAIL rdg_m_addr got=%h exp=0", bus.m_addr); end
    if (bus.m_write !== 1'b0)  begin failures++; $display("FAIL rdg_m_write got=%b exp=0", bus.m_write); end
    if (bus.m_wdata !== 32'h0) begin failures++; $display("FAIL rdg_m_wdata got=%h exp=0", bus.m_wdata); end
    if (bus.dready_n !== 1'b1) begin failures++; $display("FAIL rdg_rdy got=%b exp=1", bus.dready_n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.dready_n !== 1'b1 || bus.m_req !== 1'b0) begin
        failures++; $display("FAIL rdg_quiet cyc=%0d rdy_n=%b m_req=%b exp 1/0", i, bus.dready_n, bus.m_req);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur;
    int          n, last;
    cur = 32'h1000;
    n = 0;
    last = -1;
    apply_reset();
    auto_ack = 1'b1;
    bus.ireq = 1'b1; bus.iaddr = cur;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bus.m_req === 1'b1) begin
        checks++;
        if (bus.m_addr !== cur) begin failures++; $display("FAIL b2b_addr got=%h exp=%h", bus.m_addr, cur); end
      end
      if (bus.iready_n === 1'b0) begin
        checks++;
        if (bus.idata !== (cur ^ 32'h5A5A_0000)) begin
          failures++; $display("FAIL b2b_data got=%h exp=%h", bus.idata, cur ^ 32'h5A5A_0000);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", c - last); end
        end
        last = c;
        cur = cur + 32'h4;
        bus.iaddr = cur;
        n++;
      end
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
    idle_inputs();
    tick();
    auto_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_store();
    test_starvation();
    test_misaligned();
    test_timeout();
    test_reset_in_dgnt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-ported memory bus between the core's instruction-fetch port and data port. Sits between the core and the unified memory/cache. Data accesses normally win arbitration; a bounded starvation guard lets instruction fetch in. The block also checks alignment and enforces an access timeout. It converts the core's active-low `iready_n`/`dready_n` completion strobes to and from a registered memory req/ack handshake.

## Interface
Parameters:
- `DSTARVE`, default 4: consecutive data grants allowed while a fetch waits; must be 1..15.
- `TIMEOUT`, default 1023: maximum granted cycles without `m_ack`; 0 disables the timeout; 16-bit.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ireq` in 1: fetch request; held until `iready_n` pulses low.
- `iaddr` in 32: fetch address; stable while `ireq`=1.
- `idata` out 32: fetched word; valid when `iready_n`=0.
- `iready_n` out 1: active-low one-cycle fetch completion.
- `ierr` out 1: fetch error (misaligned or timeout); valid with `iready_n`=0.
- `dreq` in 1: data request; held until `dready_n` pulses low.
- `dwrite` in 1: 1=store, 0=load.
- `dsize` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `daddr` in 32: data address.
- `dwdata` in 32: store data.
- `drdata` out 32: load data; valid when `dready_n`=0.
- `dready_n` out 1: active-low one-cycle data completion.
- `dbusy` out 1: data access granted and in flight.
- `derr` out 1: data error (misaligned or timeout); valid with `dready_n`=0.
- `m_req` out 1: memory request; held until `m_ack`.
- `m_write` out 1: memory write enable.
- `m_size` out 2: memory access size.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data; sampled when `m_ack`=1.
- `m_ack` in 1: memory completion; may rise in the first `m_req` cycle.

## Operation
- FSM states: IDLE, IGNT, DGNT, RESP.
- Requests are sampled only in IDLE.
- IDLE with `dreq`=1 and not (`ireq`=1 and `dcnt`==`DSTARVE`): grant data.
  - Misaligned or illegal access goes directly to RESP with `derr`=1 and no `m_req`. This covers word with `daddr[1:0]`≠0, half with `daddr[0]`=1, and `dsize`=11.
  - Otherwise go to DGNT. Latch `daddr`/`dsize`/`dwrite`/`dwdata` into the `m_*` registers.
- IDLE otherwise with `ireq`=1: grant fetch.
  - `iaddr[1:0]`≠0 goes to RESP with `ierr`=1.
  - Otherwise go to IGNT with `m_size`=10 and `m_write`=0.
- `dcnt` is a 4-bit counter.
  - +1 on each data grant made while `ireq`=1.
  - Cleared on a fetch grant, and on any data grant made while `ireq`=0.
  - Saturates at `DSTARVE`.
- IGNT/DGNT: `m_req`=1 with stable fields.
  - On `m_ack`=1: register `m_rdata` into `idata`/`drdata` and go to RESP.
  - Timeout: `tcnt` counts granted cycles. If `tcnt` reaches `TIMEOUT` without `m_ack`, drop `m_req`, load data 0, set err, go to RESP.
- RESP lasts one cycle.
  - Pulse `iready_n` or `dready_n` low, matching the granted side.
  - Hold the error flag for that same cycle.
  - Next state is IDLE.
- `dbusy`=1 exactly in DGNT cycles.
- For stores, `drdata` is 0.

## Timing
- Reset values:
  - state IDLE; `m_req`, `m_write`, `dbusy`, `ierr`, `derr` = 0.
  - `iready_n` = `dready_n` = 1.
  - `m_size` = 00; `m_addr`, `m_wdata`, `idata`, `drdata` = 0; `dcnt` = `tcnt` = 0.
- All outputs are registered; no combinational path from input to output.
- Request sampled in IDLE at cycle t → `m_req`=1 at t+1.
- `m_ack` at cycle a (a ≥ t+1) → ready low and data valid at a+1 → IDLE at a+2.
- Minimum throughput is 3 cycles per access (zero-wait memory).
- A request still asserted in the RESP cycle is ignored. It is treated as a new request if still high in IDLE at a+2. This permits back-to-back streams.
- Simultaneous `ireq` and `dreq` in IDLE: data wins unless `dcnt`==`DSTARVE`.
- A request that changes while not granted is taken at its value in the IDLE sample cycle.
- `m_ack` outside IGNT/DGNT is ignored.
- `rst` in any state: the next cycle is IDLE with reset values. The in-flight access is abandoned and no ready strobe is given.

## Test plan
- Single load, memory acks 2 cycles after `m_req`:
  - `dreq`=1, `dsize`=10, `daddr`=0x100, `m_rdata`=0xDEADBEEF.
  - Expect `m_req` rising at t+1, `dbusy`=1 for 2 cycles.
  - Expect `dready_n`=0 with `drdata`=0xDEADBEEF at t+3, and no further strobe.
- Simultaneous `ireq`/`dreq` held continuously, `DSTARVE`=4, zero-wait memory → grant order D,D,D,D,I,D,D,D,D,I.
- Misaligned store, word at `daddr`=0x102:
  - `m_req` never asserts.
  - `dready_n`=0 and `derr`=1 at t+1.
- Timeout, `TIMEOUT`=8, memory never acks fetch at `iaddr`=0x40:
  - `m_req` high exactly 8 cycles.
  - Then `iready_n`=0 with `ierr`=1 and `idata`=0.
- Reset during DGNT: `rst` pulsed on the 2nd granted cycle → `m_req`=0 next cycle, all outputs at reset values, no `dready_n` pulse.
- Back-to-back fetches with `ireq` held and zero-wait memory:
  - `iready_n` low every 3rd cycle.
  - `m_addr` follows `iaddr` updated in each RESP cycle.
